// File: rtl/bpm_fusion_tracker.sv
// bpm_fusion_tracker: fuses per-band tempo estimates into a weighted, smoothed BPM
// and drives a beat pulse at that tempo from a phase accumulator.
module bpm_fusion_tracker #(
  parameter int unsigned NBANDS       = 3,
  parameter int unsigned BPM_W        = 16,
  parameter int unsigned WGT_W        = 4,
  parameter int unsigned BPM_MIN      = 60,
  parameter int unsigned BPM_MAX      = 200,
  parameter int unsigned STALE_FRAMES = 8,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned CLK_HZ       = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NBANDS*BPM_W-1:0] bpm_in,
  input  logic [NBANDS-1:0]       bpm_in_valid,
  input  logic [NBANDS*WGT_W-1:0] weights,
  input  logic                    frame_tick,
  output logic [BPM_W-1:0]        bpm_out,
  output logic                    bpm_out_valid,
  output logic                    beat_pulse,
  output logic [NBANDS-1:0]       band_live,
  output logic                    busy
);
  localparam int unsigned LOG_NB  = $clog2(NBANDS);
  localparam int unsigned NUM_W   = BPM_W + WGT_W + LOG_NB;
  localparam int unsigned DEN_W   = WGT_W + LOG_NB;
  localparam int unsigned AGE_W   = $clog2(STALE_FRAMES + 1);
  localparam int unsigned BAND_CW = $clog2(NBANDS + 1);
  localparam int unsigned BIT_CW  = (BPM_W > 1) ? $clog2(BPM_W) : 1;
  localparam longint unsigned PERIOD = 64'(CLK_HZ) * 64'd60;
  localparam int unsigned PH_W    = $clog2(PERIOD) + 1;

  localparam logic [BPM_W-1:0] MIN_V    = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0] MAX_V    = BPM_W'(BPM_MAX);
  localparam logic [AGE_W-1:0] STALE_V  = AGE_W'(STALE_FRAMES);
  localparam logic [PH_W-1:0]  PERIOD_V = PH_W'(PERIOD);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, UPDATE} state_e;

  logic [BPM_W-1:0]  hold_q [NBANDS];
  logic [BPM_W-1:0]  hold_d [NBANDS];
  logic [AGE_W-1:0]  age_q  [NBANDS];
  logic [AGE_W-1:0]  age_d  [NBANDS];
  logic [NBANDS-1:0] held_q, held_d, live_q, live_d, accept;
  logic              any_accept;

  state_e             state_q;
  logic               pending_q, have_est_q, busy_q, bpm_valid_q, beat_q;
  logic [NUM_W-1:0]   num_q;
  logic [DEN_W-1:0]   den_q, rem_q;
  logic [BPM_W-1:0]   quo_q, bpm_q;
  logic [BAND_CW-1:0] band_idx_q;
  logic [BIT_CW-1:0]  bit_cnt_q;
  logic [PH_W-1:0]    phase_q, ph_sum;

  logic [WGT_W-1:0]        cur_w;
  logic [BPM_W-1:0]        cur_bpm;
  logic                    cur_live;
  logic [DEN_W:0]          trial, trial_sub;
  logic signed [BPM_W:0]   diff, step;

  always_comb begin
    held_d     = held_q;
    accept     = '0;
    live_d     = '0;
    for (int unsigned b = 0; b < NBANDS; b++) begin
      hold_d[b] = hold_q[b];
      age_d[b]  = age_q[b];
      accept[b] = bpm_in_valid[b] && (bpm_in[b*BPM_W +: BPM_W] >= MIN_V) &&
                  (bpm_in[b*BPM_W +: BPM_W] <= MAX_V);
      if (accept[b]) begin
        hold_d[b] = bpm_in[b*BPM_W +: BPM_W];
        held_d[b] = 1'b1;
        age_d[b]  = '0;
      end else if (frame_tick && (age_q[b] != STALE_V)) begin
        age_d[b] = age_q[b] + 1'b1;
      end
      live_d[b] = held_d[b] && (age_d[b] < STALE_V);
    end
    any_accept = |accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < NBANDS; b++) begin
        hold_q[b] <= '0;
        age_q[b]  <= '0;
      end
      held_q <= '0;
      live_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NBANDS; b++) begin
        hold_q[b] <= hold_d[b];
        age_q[b]  <= age_d[b];
      end
      held_q <= held_d;
      live_q <= live_d;
    end
  end

  always_comb begin
    cur_w    = '0;
    cur_bpm  = '0;
    cur_live = 1'b0;
    for (int unsigned b = 0; b < NBANDS; b++) begin
      if (band_idx_q == BAND_CW'(b)) begin
        cur_w    = weights[b*WGT_W +: WGT_W];
        cur_bpm  = hold_q[b];
        cur_live = live_q[b];
      end
    end
    trial     = {rem_q, quo_q[BPM_W-1]};
    trial_sub = trial - {1'b0, den_q};
    diff      = $signed({1'b0, quo_q}) - $signed({1'b0, bpm_q});
    step      = diff >>> SMOOTH_SHIFT;
  end

  // ACCUM spends one extra slot after the last band to decide between DIVIDE and IDLE
  // and to seed the divider with the top DEN_W bits of the numerator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      band_idx_q  <= '0;
      bit_cnt_q   <= '0;
      have_est_q  <= 1'b0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bpm_valid_q <= 1'b0;
      if ((state_q != IDLE) && any_accept) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pending_q || any_accept) begin
            state_q    <= ACCUM;
            pending_q  <= 1'b0;
            num_q      <= '0;
            den_q      <= '0;
            band_idx_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (band_idx_q == BAND_CW'(NBANDS)) begin
            if (den_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              rem_q     <= num_q[NUM_W-1 -: DEN_W];
              quo_q     <= num_q[BPM_W-1:0];
              bit_cnt_q <= '0;
              state_q   <= DIVIDE;
            end
          end else begin
            if (cur_live && (cur_w != '0)) begin
              num_q <= num_q + NUM_W'(cur_w) * NUM_W'(cur_bpm);
              den_q <= den_q + DEN_W'(cur_w);
            end
            band_idx_q <= band_idx_q + 1'b1;
          end
        end
        DIVIDE: begin
          if (trial >= {1'b0, den_q}) begin
            rem_q <= DEN_W'(trial_sub);
            quo_q <= {quo_q[BPM_W-2:0], 1'b1};
          end else begin
            rem_q <= DEN_W'(trial);
            quo_q <= {quo_q[BPM_W-2:0], 1'b0};
          end
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_CW'(BPM_W - 1)) state_q <= UPDATE;
        end
        UPDATE: begin
          bpm_q       <= have_est_q ? (bpm_q + BPM_W'(step)) : quo_q;
          have_est_q  <= 1'b1;
          bpm_valid_q <= 1'b1;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ph_sum = phase_q + PH_W'(bpm_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      beat_q  <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      if ((state_q == UPDATE) && !have_est_q) begin
        phase_q <= '0;
      end else if (have_est_q) begin
        if (ph_sum >= PERIOD_V) begin
          phase_q <= ph_sum - PERIOD_V;
          beat_q  <= 1'b1;
        end else begin
          phase_q <= ph_sum;
        end
      end
    end
  end

  assign bpm_out       = bpm_q;
  assign bpm_out_valid = bpm_valid_q;
  assign beat_pulse    = beat_q;
  assign band_live     = live_q;
  assign busy          = busy_q;
endmodule

// File: doc/bpm_fusion_tracker.md
BPM_FUSION_TRACKER -- requirements
Module: bpm_fusion_tracker

Interface
REQ-001 SHALL have parameter NBANDS, default 3, number of per-band BPM estimators fused.
REQ-002 SHALL have parameter BPM_W, default 16, width of every BPM value.
REQ-003 SHALL have parameter WGT_W, default 4, width of each unsigned band weight.
REQ-004 SHALL have parameter BPM_MIN / BPM_MAX, default 60 / 200, accepted input range (inclusive).
REQ-005 SHALL have parameter STALE_FRAMES, default 8, frame ticks without a new estimate after which a band is dropped.
REQ-006 SHALL have parameter SMOOTH_SHIFT, default 2, exponential-smoothing shift.
REQ-007 SHALL have parameter CLK_HZ, default 50000000, clk frequency for beat generation.
REQ-008 clk  input  1  system clock; all logic on rising edge.
REQ-009 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-010 bpm_in  input  NBANDS*BPM_W  per-band BPM estimates, band b in bits [b*BPM_W +: BPM_W].
REQ-011 bpm_in_valid  input  NBANDS  per-band one-cycle valid strobes.
REQ-012 weights  input  NBANDS*WGT_W  per-band fusion weights, sampled during ACCUM.
REQ-013 frame_tick  input  1  one-cycle strobe per analysis frame.
REQ-014 bpm_out  output  BPM_W  smoothed fused BPM.
REQ-015 bpm_out_valid  output  1  one-cycle strobe on each bpm_out update.
REQ-016 beat_pulse  output  1  one-cycle pulse at the fused tempo.
REQ-017 band_live  output  NBANDS  per-band live flag.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 Per band: bpm_in_valid with value in [BPM_MIN,BPM_MAX] SHALL latch value into hold register, set held flag, clear age, set pending; out-of-range values SHALL be ignored entirely.
REQ-020 Per band age SHALL increment on frame_tick, saturating at STALE_FRAMES; accepted valid and frame_tick in the same cycle SHALL give age 0.
REQ-021 band_live[b] SHALL equal held[b] AND age[b] < STALE_FRAMES, registered.
REQ-022 FSM states IDLE, ACCUM, DIVIDE, UPDATE; IDLE->ACCUM when pending (pending cleared on entry); ACCUM SHALL visit bands 0..NBANDS-1 one per cycle.
REQ-023 ACCUM: for each band with band_live and weight != 0, num += w*bpm, den += w; num width BPM_W+WGT_W+clog2(NBANDS), den width WGT_W+clog2(NBANDS), no overflow possible.
REQ-024 After last band: den == 0 SHALL return to IDLE with no output update; otherwise DIVIDE.
REQ-025 DIVIDE SHALL compute q = floor(num/den) by restoring division, one quotient bit per cycle, exactly BPM_W cycles.
REQ-026 UPDATE: first estimate since reset SHALL load bpm_out = q; thereafter bpm_out += (q - bpm_out) arithmetic-shifted right by SMOOTH_SHIFT (signed, floor); bpm_out_valid high for this one cycle; next state IDLE.
REQ-027 Latency: accepted valid sampled in IDLE at cycle T SHALL produce bpm_out_valid at cycle T+NBANDS+BPM_W+2.
REQ-028 Valids accepted while busy SHALL update hold registers immediately and set pending; one recompute SHALL follow return to IDLE, regardless of how many arrived.
REQ-029 Beat generator: phase accumulator of width clog2(60*CLK_HZ)+1 SHALL add bpm_out each cycle once a first estimate exists; when phase >= 60*CLK_HZ it SHALL subtract 60*CLK_HZ and assert beat_pulse one cycle.
REQ-030 Phase SHALL be cleared on the first-estimate UPDATE only; later updates SHALL change rate without clearing phase.

Reset
REQ-031 reset low SHALL asynchronously clear: FSM to IDLE, hold, held, age, pending, num, den, quotient, phase, first-estimate flag, and all outputs (bpm_out=0, bpm_out_valid=0, beat_pulse=0, band_live=0, busy=0), including mid-DIVIDE.
REQ-032 No beat_pulse SHALL occur before the first bpm_out_valid after reset.

Verification
REQ-033 Weights 3,1,3; bands 120,120,120 valid together -> bpm_out=120 at T+21, bpm_out_valid one cycle.
REQ-034 Then bands 100,150,100 -> q=750/7=107, bpm_out=120+((-13)>>>2)=116.
REQ-035 Band 1 value 250 -> ignored, no pending, no recompute; band 1 silent for 8 frame_ticks -> band_live=3'b101, next fuse excludes band 1.
REQ-036 CLK_HZ=1000, bpm_out=120 -> beat_pulse every 500 cycles, first 500 cycles after first update.
REQ-037 All weights 0 with valid input -> busy for NBANDS+1 cycles, no bpm_out_valid, bpm_out unchanged.
REQ-038 reset asserted during DIVIDE -> all outputs 0 same cycle; after release no bpm_out_valid until a new accepted valid.
